// File: rtl/combinational_selftest_seq_if.sv
// Handshake and pattern bus between board control, the self-test
// sequencer and the combinational block under test.
interface combinational_selftest_seq_if;
   logic       start;
   logic [4:0] in_drive;
   logic       in0_out;
   logic       in0_and_in1_out;
   logic       in0_or_in1_out;
   logic       not_in2_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [5:0] err_count;
   logic [4:0] fail_pattern;
   logic [3:0] fail_mask;

   modport master (
      output start,
      output in0_out,
      output in0_and_in1_out,
      output in0_or_in1_out,
      output not_in2_out,
      input  in_drive,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  fail_pattern,
      input  fail_mask
   );

   modport slave (
      input  start,
      input  in0_out,
      input  in0_and_in1_out,
      input  in0_or_in1_out,
      input  not_in2_out,
      output in_drive,
      output busy,
      output done,
      output pass,
      output err_count,
      output fail_pattern,
      output fail_mask
   );
endinterface

// File: rtl/combinational_selftest_seq.sv
// Built-in self-test sequencer: sweeps all 32 input patterns through the
// combinational block, counts mismatches and latches the first failure.
module combinational_selftest_seq #(
   parameter int SETTLE_CYCLES = 4,
   parameter bit STOP_ON_FAIL  = 1'b1
) (
   input logic clk,
   input logic rst,
   combinational_selftest_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [4:0] pat;
   logic [7:0] cnt;
   logic [4:0] drive;
   logic       running;
   logic       finished;
   logic       ok;
   logic [5:0] errs;
   logic [4:0] first_pat;
   logic [3:0] first_mask;

   logic [3:0] expect_v;
   logic [3:0] observed;
   logic [3:0] mism;
   logic [5:0] err_next;
   logic       last;

   always_comb begin
      expect_v = {~pat[2], pat[0] | pat[1], pat[0] & pat[1], pat[0]};
      observed = {bus.not_in2_out, bus.in0_or_in1_out,
                  bus.in0_and_in1_out, bus.in0_out};
      mism     = expect_v ^ observed;
      err_next = errs + {5'd0, |mism};
      // p=31 is tested before any increment so the pattern never wraps
      last     = ((|mism) && STOP_ON_FAIL) || (pat == 5'd31);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pat        <= 5'd0;
         cnt        <= 8'd0;
         drive      <= 5'd0;
         running    <= 1'b0;
         finished   <= 1'b0;
         ok         <= 1'b0;
         errs       <= 6'd0;
         first_pat  <= 5'd0;
         first_mask <= 4'd0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state      <= DRIVE;
                  pat        <= 5'd0;
                  drive      <= 5'd0;
                  running    <= 1'b1;
                  finished   <= 1'b0;
                  ok         <= 1'b0;
                  errs       <= 6'd0;
                  first_pat  <= 5'd0;
                  first_mask <= 4'd0;
               end
            end
            DRIVE: begin
               cnt   <= SETTLE_LOAD;
               state <= SETTLE;
            end
            SETTLE: begin
               if (cnt == 8'd0) begin
                  state <= CHECK;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            CHECK: begin
               if (|mism) begin
                  errs <= err_next;
                  if (errs == 6'd0) begin
                     first_pat  <= pat;
                     first_mask <= mism;
                  end
               end
               if (last) begin
                  state    <= DONE;
                  drive    <= 5'd0;
                  running  <= 1'b0;
                  finished <= 1'b1;
                  ok       <= (err_next == 6'd0);
               end else begin
                  pat   <= pat + 5'd1;
                  drive <= pat + 5'd1;
                  state <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_drive     = drive;
   assign bus.busy         = running;
   assign bus.done         = finished;
   assign bus.pass         = ok;
   assign bus.err_count    = errs;
   assign bus.fail_pattern = first_pat;
   assign bus.fail_mask    = first_mask;

endmodule

// File: tb/tb_combinational_selftest_seq.sv
// Bench for the self-test sequencer: two instances (run-all and
// stop-on-fail) driving a behavioural block with injectable faults.
module tb_combinational_selftest_seq;

   localparam int S = 4;
   localparam int P = S + 2;

   logic clk = 1'b0;
   logic rst;
   logic start;
   int   fault;
   logic sel;

   always #5 clk = ~clk;

   combinational_selftest_seq_if ia ();
   combinational_selftest_seq_if ib ();

   combinational_selftest_seq #(
      .SETTLE_CYCLES(S),
      .STOP_ON_FAIL (1'b0)
   ) dut_all (
      .clk(clk),
      .rst(rst),
      .bus(ia)
   );

   combinational_selftest_seq #(
      .SETTLE_CYCLES(S),
      .STOP_ON_FAIL (1'b1)
   ) dut_stop (
      .clk(clk),
      .rst(rst),
      .bus(ib)
   );

   // fault 1: and output stuck-at-0; fault 2: not_in2 inverted
   function automatic logic [3:0] blk(input logic [4:0] p, input int f);
      logic [3:0] r;
      r = {~p[2], p[0] | p[1], p[0] & p[1], p[0]};
      if (f == 1) r[1] = 1'b0;
      if (f == 2) r[3] = p[2];
      return r;
   endfunction

   assign ia.start = start;
   assign ib.start = start;
   assign {ia.not_in2_out, ia.in0_or_in1_out,
           ia.in0_and_in1_out, ia.in0_out} = blk(ia.in_drive, fault);
   assign {ib.not_in2_out, ib.in0_or_in1_out,
           ib.in0_and_in1_out, ib.in0_out} = blk(ib.in_drive, fault);

   logic       s_busy, s_done, s_pass;
   logic [5:0] s_err;
   logic [4:0] s_fp, s_drv;
   logic [3:0] s_mask;

   assign s_busy = sel ? ib.busy         : ia.busy;
   assign s_done = sel ? ib.done         : ia.done;
   assign s_pass = sel ? ib.pass         : ia.pass;
   assign s_err  = sel ? ib.err_count    : ia.err_count;
   assign s_fp   = sel ? ib.fail_pattern : ia.fail_pattern;
   assign s_drv  = sel ? ib.in_drive     : ia.in_drive;
   assign s_mask = sel ? ib.fail_mask    : ia.fail_mask;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int fault;
      bit stop;
      int err;
      int fp;
      int mask;
      bit pass;
      int done_at;
   } vec_t;

   vec_t v[6];

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // rise is the spec cycle number of done relative to the start edge
   task automatic do_run(input int mid, input bit drv_chk, output int rise);
      int drv_bad;
      logic [4:0] e;
      rise    = -1;
      drv_bad = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (s_done) begin
            rise = n + 1;
            break;
         end
         e = 5'(n / P);
         if (s_drv !== e || s_busy !== 1'b1) drv_bad++;
         if (n == mid) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      if (drv_chk) chk("in_drive_seq", drv_bad, 0);
   endtask

   task automatic chk_results(input string tag, input vec_t x, input int rise);
      chk({tag, "_done_at"}, rise, x.done_at);
      chk({tag, "_err"}, s_err, x.err);
      chk({tag, "_fp"}, s_fp, x.fp);
      chk({tag, "_mask"}, s_mask, x.mask);
      chk({tag, "_pass"}, s_pass, x.pass);
      chk({tag, "_idle_out"}, {s_drv, s_busy}, 0);
   endtask

   initial begin
      int   rise;
      bit   found;
      vec_t clean;

      v[0] = '{fault: 0, stop: 0, err: 0,  fp: 0, mask: 0, pass: 1, done_at: 193};
      v[1] = '{fault: 1, stop: 0, err: 8,  fp: 3, mask: 2, pass: 0, done_at: 193};
      v[2] = '{fault: 1, stop: 1, err: 1,  fp: 3, mask: 2, pass: 0, done_at: 25};
      v[3] = '{fault: 2, stop: 0, err: 32, fp: 0, mask: 8, pass: 0, done_at: 193};
      v[4] = '{fault: 2, stop: 1, err: 1,  fp: 0, mask: 8, pass: 0, done_at: 7};
      v[5] = '{fault: 0, stop: 1, err: 0,  fp: 0, mask: 0, pass: 1, done_at: 193};
      clean = v[0];

      fault = 0;
      sel   = 1'b0;
      rst   = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_outs_all", {s_drv, s_busy, s_done, s_pass, s_err, s_fp, s_mask}, 0);
         chk("rst_outs_stop", {ib.in_drive, ib.busy, ib.done, ib.pass,
                               ib.err_count, ib.fail_pattern, ib.fail_mask}, 0);
      end
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_hold", {s_busy, s_done, s_drv}, 0);

      for (int i = 0; i < 6; i++) begin
         fault = v[i].fault;
         sel   = v[i].stop;
         do_reset();
         do_run(-1, i == 0 || i == 2, rise);
         chk_results($sformatf("vec%0d", i), v[i], rise);
      end

      fault = 0;
      sel   = 1'b0;
      do_reset();
      do_run(50, 1'b1, rise);
      chk_results("busy_start", clean, rise);

      fault = 1;
      do_run(-1, 1'b0, rise);
      chk_results("done_restart", v[1], rise);

      fault = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("restart_cleared", {s_done, s_busy, s_pass, s_err, s_fp, s_mask},
          {1'b0, 1'b1, 1'b0, 6'd0, 5'd0, 4'd0});

      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (s_drv == 5'd10) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("reach_p10", found, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrun_rst", {s_drv, s_busy, s_done, s_pass, s_err, s_fp, s_mask}, 0);
      repeat (2) @(negedge clk);
      chk("midrun_rst_idle", {s_busy, s_done}, 0);

      do_run(-1, 1'b1, rise);
      chk_results("after_rst", clean, rise);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
